// File: rtl/video_timing_gen.sv
// Runtime-programmable raster timing generator with a shadow/live timing bank swapped only at a
// frame boundary after a commit. Optional `SYNC_POLARITY_EN adds hsync/vsync inversion bits.
module video_timing_gen #(
  parameter int X_BITS   = 11,
  parameter int Y_BITS   = 10,
  parameter int X0_INIT  = -48,
  parameter int XFP_INIT = 640,
  parameter int XS_INIT  = 656,
  parameter int X1_INIT  = 751,
  parameter int Y0_INIT  = -33,
  parameter int YFP_INIT = 480,
  parameter int YS_INIT  = 490,
  parameter int Y1_INIT  = 491
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_we,
  input  logic [3:0]               cfg_addr,
  input  logic [7:0]               cfg_data,
  input  logic                     cfg_commit,
  output logic                     cfg_pending,
  output logic signed [X_BITS-1:0] x,
  output logic signed [Y_BITS-1:0] y,
  output logic                     active,
  output logic                     hsync,
  output logic                     vsync,
  output logic                     line_start,
  output logic                     frame_start
);

  typedef logic signed [X_BITS-1:0] xval_t;
  typedef logic signed [Y_BITS-1:0] yval_t;

  // Bank index within each axis: 0 = start, 1 = front porch, 2 = sync, 3 = last
  localparam xval_t XINIT [4] = '{xval_t'(X0_INIT), xval_t'(XFP_INIT), xval_t'(XS_INIT),
                                  xval_t'(X1_INIT)};
  localparam yval_t YINIT [4] = '{yval_t'(Y0_INIT), yval_t'(YFP_INIT), yval_t'(YS_INIT),
                                  yval_t'(Y1_INIT)};

  xval_t       sh_x_q [4];
  xval_t       lv_x_q [4];
  yval_t       sh_y_q [4];
  yval_t       lv_y_q [4];
  xval_t       x_q, x_d;
  yval_t       y_q, y_d;
  logic        pending_q, pending_d;
  logic        last_x, last_y, apply;
  logic        wr_x, wr_y;
  logic [1:0]  wr_idx;

  assign wr_idx = cfg_addr[2:1];
  assign wr_x   = cfg_we && !cfg_addr[3];
  assign wr_y   = cfg_we && cfg_addr[3];

  always_comb begin
    last_x    = (x_q == lv_x_q[3]);
    last_y    = (y_q == lv_y_q[3]);
    apply     = last_x && last_y && (pending_q || cfg_commit);
    pending_d = (pending_q || cfg_commit) && !apply;
    x_d       = x_q + xval_t'(1);
    y_d       = y_q;
    if (last_x) begin
      if (apply) begin
        x_d = sh_x_q[0];
        y_d = sh_y_q[0];
      end else begin
        x_d = lv_x_q[0];
        y_d = last_y ? lv_y_q[0] : y_q + yval_t'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q       <= '0;
      y_q       <= '0;
      pending_q <= 1'b0;
      sh_x_q    <= XINIT;
      lv_x_q    <= XINIT;
      sh_y_q    <= YINIT;
      lv_y_q    <= YINIT;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      pending_q <= pending_d;
      // Live copy takes the pre-write shadow; a same-cycle write stays in shadow only
      if (apply) begin
        lv_x_q <= sh_x_q;
        lv_y_q <= sh_y_q;
      end
      if (wr_x) begin
        if (cfg_addr[0]) sh_x_q[wr_idx][X_BITS-1:8] <= cfg_data[X_BITS-9:0];
        else             sh_x_q[wr_idx][7:0]        <= cfg_data;
      end
      if (wr_y) begin
        if (cfg_addr[0]) sh_y_q[wr_idx][Y_BITS-1:8] <= cfg_data[Y_BITS-9:0];
        else             sh_y_q[wr_idx][7:0]        <= cfg_data;
      end
    end
  end

`ifdef SYNC_POLARITY_EN
  logic sh_hpol_q, sh_vpol_q, hpol_q, vpol_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_hpol_q <= 1'b0;
      sh_vpol_q <= 1'b0;
      hpol_q    <= 1'b0;
      vpol_q    <= 1'b0;
    end else begin
      if (apply) begin
        hpol_q <= sh_hpol_q;
        vpol_q <= sh_vpol_q;
      end
      if (cfg_we && cfg_addr == 4'd7)  sh_hpol_q <= cfg_data[7];
      if (cfg_we && cfg_addr == 4'd15) sh_vpol_q <= cfg_data[7];
    end
  end

  assign hsync = (x_q >= lv_x_q[2]) ^ hpol_q;
  assign vsync = (y_q >= lv_y_q[2]) ^ vpol_q;
`else
  assign hsync = (x_q >= lv_x_q[2]);
  assign vsync = (y_q >= lv_y_q[2]);
`endif

  assign x           = x_q;
  assign y           = y_q;
  assign cfg_pending = pending_q;
  assign active      = !x_q[X_BITS-1] && (x_q < lv_x_q[1]) && !y_q[Y_BITS-1] && (y_q < lv_y_q[1]);
  assign line_start  = (x_q == lv_x_q[0]);
  assign frame_start = line_start && (y_q == lv_y_q[0]);

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: small-timing instance checked every cycle against a field-level
// model, plus a default-timing instance checked over its first line.
module tb_video_timing_gen;
  localparam int XB = 11;
  localparam int YB = 10;
  localparam int PX0 = -8, PXFP = 20, PXS = 24, PX1 = 29;
  localparam int PY0 = -3, PYFP = 10, PYS = 12, PY1 = 13;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cfg_we = 1'b0, cfg_commit = 1'b0;
  logic [3:0] cfg_addr = '0;
  logic [7:0] cfg_data = '0;
  logic cfg_pending, active, hsync, vsync, line_start, frame_start;
  logic signed [XB-1:0] x;
  logic signed [YB-1:0] y;

  logic d_pend, d_act, d_hs, d_vs, d_ls, d_fs;
  logic signed [XB-1:0] d_x;
  logic signed [YB-1:0] d_y;

  int nvec = 0, nerr = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  video_timing_gen #(
    .X_BITS(XB), .Y_BITS(YB), .X0_INIT(PX0), .XFP_INIT(PXFP), .XS_INIT(PXS), .X1_INIT(PX1),
    .Y0_INIT(PY0), .YFP_INIT(PYFP), .YS_INIT(PYS), .Y1_INIT(PY1)
  ) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_commit(cfg_commit), .cfg_pending(cfg_pending), .x(x), .y(y), .active(active),
    .hsync(hsync), .vsync(vsync), .line_start(line_start), .frame_start(frame_start)
  );

  video_timing_gen dut_def (
    .clk(clk), .reset(reset), .cfg_we(1'b0), .cfg_addr(4'd0), .cfg_data(8'd0),
    .cfg_commit(1'b0), .cfg_pending(d_pend), .x(d_x), .y(d_y), .active(d_act),
    .hsync(d_hs), .vsync(d_vs), .line_start(d_ls), .frame_start(d_fs)
  );

  // Model: raw 16-bit byte pairs per field; field value is the low axis-width bits, signed
  logic [15:0] sraw [8];
  logic [15:0] lraw [8];
  logic [15:0] snap [8];
  int mx, my;
  bit mpend, m_lastx, m_apply;
  int init_v [8] = '{PX0, PXFP, PXS, PX1, PY0, PYFP, PYS, PY1};

  function automatic int wid(input int f);
    return (f < 4) ? XB : YB;
  endfunction

  function automatic int fld(input logic [15:0] r, input int f);
    int w = wid(f);
    int v = int'(r) & ((1 << w) - 1);
    if (v >= (1 << (w - 1))) v -= (1 << w);
    return v;
  endfunction

  function automatic int wrap(input int v, input int w);
    int m = 1 << w;
    int r = ((v % m) + m) % m;
    if (r >= m / 2) r -= m;
    return r;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      mx = 0;
      my = 0;
      mpend = 0;
      for (int i = 0; i < 8; i++) begin
        sraw[i] = 16'(init_v[i] & ((1 << wid(i)) - 1));
        lraw[i] = sraw[i];
      end
    end else begin
      m_lastx = (mx == fld(lraw[3], 3));
      m_apply = m_lastx && (my == fld(lraw[7], 7)) && (mpend || cfg_commit);
      snap = sraw;
      if (cfg_we) begin
        if (cfg_addr[0]) sraw[cfg_addr[3:1]][15:8] = cfg_data;
        else             sraw[cfg_addr[3:1]][7:0]  = cfg_data;
      end
      if (m_apply) begin
        lraw = snap;
        mx = fld(lraw[0], 0);
        my = fld(lraw[4], 4);
        mpend = 0;
      end else begin
        mpend = mpend || cfg_commit;
        if (m_lastx) begin
          mx = fld(lraw[0], 0);
          my = (my == fld(lraw[7], 7)) ? fld(lraw[4], 4) : wrap(my + 1, YB);
        end else begin
          mx = wrap(mx + 1, XB);
        end
      end
    end
  end

  task automatic cmp_cycle();
    bit ph = 0, pv = 0;
    logic [5:0] ef, af;
    int ax = x, ay = y;
`ifdef SYNC_POLARITY_EN
    ph = lraw[3][15];
    pv = lraw[7][15];
`endif
    ef = {mpend,
          (mx >= 0 && mx < fld(lraw[1], 1) && my >= 0 && my < fld(lraw[5], 5)),
          (mx >= fld(lraw[2], 2)) ^ ph,
          (my >= fld(lraw[6], 6)) ^ pv,
          (mx == fld(lraw[0], 0)),
          (mx == fld(lraw[0], 0)) && (my == fld(lraw[4], 4))};
    af = {cfg_pending, active, hsync, vsync, line_start, frame_start};
    nvec++;
    if (af !== ef || ax != mx || ay != my) begin
      nerr++;
      $display("FAIL cycle@%0t: got x=%0d y=%0d pend/act/hs/vs/ls/fs=%b, expected x=%0d y=%0d %b",
               $time, ax, ay, af, mx, my, ef);
    end
  endtask

  always @(negedge clk) if (chk_en) cmp_cycle();

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    @(negedge clk);
    cfg_commit = 1'b0;
  endtask

  // Length of the next full line (line_start to line_start) and its hsync-high cycles
  task automatic measure_line(output int n, output int nhs);
    int k = 0;
    n = -1;
    nhs = -1;
    while (!line_start && k < 5000) begin @(negedge clk); k++; end
    if (!line_start) return;
    n = 0;
    nhs = 0;
    do begin
      nhs += int'(hsync);
      @(negedge clk);
      n++;
    end while (!line_start && n < 5000);
  endtask

  task automatic measure_frame(output int n, output int nvs);
    int k = 0;
    n = -1;
    nvs = -1;
    while (!frame_start && k < 5000) begin @(negedge clk); k++; end
    if (!frame_start) return;
    n = 0;
    nvs = 0;
    do begin
      nvs += int'(vsync);
      @(negedge clk);
      n++;
    end while (!frame_start && n < 5000);
  endtask

  task automatic wait_frame_start();
    int k = 0;
    while (!frame_start && k < 5000) begin @(negedge clk); k++; end
    chk("wait_frame_start", int'(frame_start), 1);
  endtask

  task automatic program_mode();
    int v [8];
    logic [7:0] hi;
    v[0] = 0 - int'($urandom_range(1, 10));
    v[1] = int'($urandom_range(1, 20));
    v[2] = v[1] + int'($urandom_range(0, 5));
    v[3] = v[2] + int'($urandom_range(0, 5));
    v[4] = 0 - int'($urandom_range(1, 4));
    v[5] = int'($urandom_range(1, 8));
    v[6] = v[5] + int'($urandom_range(0, 3));
    v[7] = v[6] + int'($urandom_range(0, 2));
    for (int f = 0; f < 8; f++) begin
      hi = v[f][15:8];
      if ((f == 3 || f == 7) && $urandom_range(0, 1) == 1) hi[7] = 1'b1;
      wr(4'(2 * f), v[f][7:0]);
      wr(4'(2 * f + 1), hi);
    end
  endtask

  initial begin
    int n, nh, cnt_hs;
    int k;
    @(negedge clk);
    chk_en = 1;
    @(negedge clk);
    // Reset state, still in reset
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    chk("rst_active", active, 1);
    chk("rst_hsync", hsync, 0);
    chk("rst_vsync", vsync, 0);
    chk("rst_line_start", line_start, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_pending", cfg_pending, 0);
    reset = 1'b0;

    // Default-timing instance: first line x=0..751 then wrap to -48
    cnt_hs = 0;
    for (int i = 0; i <= 752; i++) begin
      if (i == 0 || i == 639 || i == 640 || i == 655 || i == 656 || i >= 750) begin
        chk($sformatf("def_x@%0d", i), d_x, (i <= 751) ? i : -48);
        chk($sformatf("def_active@%0d", i), d_act, (i < 640) ? 1 : 0);
        chk($sformatf("def_hsync@%0d", i), d_hs, (i >= 656 && i <= 751) ? 1 : 0);
        chk($sformatf("def_line_start@%0d", i), d_ls, (i == 752) ? 1 : 0);
      end
      if (i <= 751) cnt_hs += int'(d_hs);
      if (i == 752) begin
        chk("def_y", d_y, 1);
        chk("def_vsync", d_vs, 0);
        chk("def_frame_start", d_fs, 0);
        chk("def_pending", d_pend, 0);
      end
      @(negedge clk);
    end
    chk("def_hsync_cycles", cnt_hs, 96);

    // Small-timing defaults: 38-cycle lines, 17 lines, sync widths 6 cycles / 2 lines
    measure_line(n, nh);
    chk("line_len_default", n, 38);
    chk("hsync_high_default", nh, 6);
    measure_frame(n, nh);
    chk("frame_len_default", n, 646);
    chk("vsync_high_default", nh, 76);

    // Shadow write without commit leaves timing alone; commit applies at boundary
    wr(4'd6, 8'd9);
    wr(4'd7, 8'd0);
    measure_line(n, nh);
    chk("line_len_no_commit", n, 38);
    commit();
    chk("pending_after_commit", cfg_pending, 1);
    wait_frame_start();
    chk("pending_after_apply", cfg_pending, 0);
    chk("x_after_apply", x, -8);
    measure_line(n, nh);
    chk("line_len_x1_9", n, 18);

    // Commit exactly on the boundary cycle
    wr(4'd6, 8'd19);
    wr(4'd7, 8'd0);
    k = 0;
    while (!(mx == fld(lraw[3], 3) && my == fld(lraw[7], 7)) && k < 5000) begin
      @(negedge clk);
      k++;
    end
    chk("boundary_found", int'(k < 5000), 1);
    commit();
    chk("boundary_commit_pending", cfg_pending, 0);
    chk("boundary_commit_x", x, -8);
    chk("boundary_commit_y", y, -3);
    chk("boundary_commit_fs", frame_start, 1);
    measure_line(n, nh);
    chk("line_len_x1_19", n, 28);

    // Reset mid-frame discards shadow writes and pending commit
    wr(4'd6, 8'd5);
    wr(4'd7, 8'd0);
    commit();
    chk("pending_before_reset", cfg_pending, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("pending_after_reset", cfg_pending, 0);
    chk("x_after_reset", x, 0);
    measure_line(n, nh);
    chk("line_len_after_reset", n, 38);
    measure_frame(n, nh);
    chk("frame_len_after_reset", n, 646);

    // Polarity bits in bit 15 of x1 / y1
    wr(4'd7, 8'h80);
    wr(4'd15, 8'h80);
    commit();
    wait_frame_start();
    measure_line(n, nh);
    measure_frame(n, k);
    chk("frame_len_pol", n, 646);
`ifdef SYNC_POLARITY_EN
    chk("hsync_high_pol", nh, 32);
    chk("vsync_high_pol", k, 570);
`else
    chk("hsync_high_pol", nh, 6);
    chk("vsync_high_pol", k, 76);
`endif

    // Randomized mode changes, commits, stray writes and resets
    for (int it = 0; it < 30; it++) begin
      program_mode();
      repeat ($urandom_range(0, 300)) @(negedge clk);
      if ($urandom_range(0, 3) == 0) wr(4'($urandom_range(0, 15)), 8'($urandom));
      commit();
      for (int c = 0; c < int'($urandom_range(100, 800)); c++) begin
        if ($urandom_range(0, 199) == 0) commit();
        else @(negedge clk);
      end
      if ($urandom_range(0, 9) == 0) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
